des_top: RTL and testbench

DES_TOP -- requirements
Module: des_top

---
 rtl/des_pkg.sv | 123 ++++++++++++
 rtl/des_round.sv | 30 +++
 rtl/des_top.sv | 115 +++++++++++
 tb/tb_des_top.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, S-boxes, key shift schedules and helpers.
package des_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int IPI_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Encrypt rotates C/D left before each round; decrypt rotates right.
   localparam int LSHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam int RSHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam int SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   // Table entries are 1-based DES bit numbers counted from the MSB.
   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [63:0] ip_inv(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IPI_T[i])];
      return y;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] e_exp(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      return n == 2 ? {x[25:0], x[27:26]} : n == 1 ? {x[26:0], x[27]} : x;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      return n == 2 ? {x[1:0], x[27:2]} : n == 1 ? {x[0], x[27:1]} : x;
   endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational Feistel round (E, key mix, S1-S8, P, swap).
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l_i,
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] l_o,
   output logic [31:0] r_o
);

   logic [47:0] x;
   logic [31:0] s;
   logic [5:0]  b;

   // S-box row is the outer bit pair, column the middle four bits.
   always_comb begin
      x = e_exp(r_i) ^ k_i;
      s = '0;
      b = '0;
      for (int j = 0; j < 8; j++) begin
         b = x[6'(42 - 6 * j) +: 6];
         s[5'(28 - 4 * j) +: 4] = 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}]);
      end
   end

   assign l_o = r_i;
   assign r_o = l_i ^ p_perm(s);

endmodule

// File: rtl/des_top.sv
// des_top: iterative DES, one round per clock, 16 cycles per block.
// Define DES_DECRYPT_EN to add decrypt_i (subkeys applied K16..K1).
module des_top
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
`ifdef DES_DECRYPT_EN
   input  logic        decrypt_i,
`endif
   input  logic [63:0] plain_text_i,
   input  logic [63:0] key_i,
   output logic [63:0] cipher_text_o,
   output logic        valid_o,
   output logic        busy_o
);

   state_t      state_q, state_d;
   logic [31:0] l_q, l_d, r_q, r_d, l_nx, r_nx;
   logic [27:0] c_q, c_d, d_q, d_d, c_rot, d_rot;
   logic [3:0]  ctr_q, ctr_d;
   logic [63:0] ct_q, ct_d;
   logic        valid_q, valid_d;
   logic [47:0] subkey;

`ifdef DES_DECRYPT_EN
   logic dec_q, dec_d;
   assign c_rot = dec_q ? rotr28(c_q, RSHIFT_T[ctr_q]) : rotl28(c_q, LSHIFT_T[ctr_q]);
   assign d_rot = dec_q ? rotr28(d_q, RSHIFT_T[ctr_q]) : rotl28(d_q, LSHIFT_T[ctr_q]);
`else
   assign c_rot = rotl28(c_q, LSHIFT_T[ctr_q]);
   assign d_rot = rotl28(d_q, LSHIFT_T[ctr_q]);
`endif

   assign subkey = pc2({c_rot, d_rot});

   des_round u_round (
      .l_i (l_q),
      .r_i (r_q),
      .k_i (subkey),
      .l_o (l_nx),
      .r_o (r_nx)
   );

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      ctr_d   = ctr_q;
      ct_d    = ct_q;
      valid_d = 1'b0;
`ifdef DES_DECRYPT_EN
      dec_d   = dec_q;
`endif
      if (state_q == IDLE) begin
         if (start_i) begin
            state_d    = RUN;
            {l_d, r_d} = ip(plain_text_i);
            {c_d, d_d} = pc1(key_i);
            ctr_d      = '0;
`ifdef DES_DECRYPT_EN
            dec_d      = decrypt_i;
`endif
         end
      end else begin
         l_d   = l_nx;
         r_d   = r_nx;
         c_d   = c_rot;
         d_d   = d_rot;
         ctr_d = ctr_q + 4'd1;
         // Final round: the output block is R16||L16, i.e. the swap undone.
         if (ctr_q == 4'd15) begin
            state_d = IDLE;
            ct_d    = ip_inv({r_nx, l_nx});
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         ctr_q   <= '0;
         ct_q    <= '0;
         valid_q <= 1'b0;
`ifdef DES_DECRYPT_EN
         dec_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         ctr_q   <= ctr_d;
         ct_q    <= ct_d;
         valid_q <= valid_d;
`ifdef DES_DECRYPT_EN
         dec_q   <= dec_d;
`endif
      end
   end

   assign cipher_text_o = ct_q;
   assign valid_o       = valid_q;
   assign busy_o        = state_q == RUN;

endmodule

// File: tb/tb_des_top.sv
// tb_des_top: directed known-answer checks for des_top.
module tb_des_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] pt = '0;
   logic [63:0] key = '0;
   logic [63:0] ct;
   logic        valid;
   logic        busy;
`ifdef DES_DECRYPT_EN
   logic        decrypt = 1'b0;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   localparam logic [63:0] KV [4] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73,
                                      64'h0000000000000000, 64'h0101010101010101};
   localparam logic [63:0] PV [4] = '{64'h0123456789ABCDEF, 64'h8787878787878787,
                                      64'h0000000000000000, 64'h0000000000000000};
   localparam logic [63:0] EV [4] = '{64'h85E813540F0AB405, 64'h0000000000000000,
                                      64'h8CA64DE9C1B123A7, 64'h8CA64DE9C1B123A7};

   des_top dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
`ifdef DES_DECRYPT_EN
      .decrypt_i     (decrypt),
`endif
      .plain_text_i  (pt),
      .key_i         (key),
      .cipher_text_o (ct),
      .valid_o       (valid),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   // Leaves the bench at the negedge just after the accept edge.
   task automatic start_op(input logic [63:0] k, input logic [63:0] p);
      @(negedge clk);
      key = k;
      pt = p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (ct !== 64'h0) begin n_fail++; $display("FAIL reset_ct got %h want %h", ct, 64'h0); end
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      rst_n = 1'b1;
   endtask

   task automatic test_vectors;
      int cyc;
      for (int v = 0; v < 4; v++) begin
         start_op(KV[v], PV[v]);
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vec%0d_busy got %b want 1", v, busy); end
         wait_valid(cyc);
         n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL vec%0d_latency got %0d want 16", v, cyc); end
         n_cmp++; if (ct !== EV[v]) begin n_fail++; $display("FAIL vec%0d_ct got %h want %h", v, ct, EV[v]); end
         @(negedge clk);
         n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_pulse got %b want 0", v, valid); end
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vec%0d_idle got %b want 0", v, busy); end
         n_cmp++; if (ct !== EV[v]) begin n_fail++; $display("FAIL vec%0d_hold got %h want %h", v, ct, EV[v]); end
      end
   endtask

   task automatic test_busy_ignore;
      int nv = 0;
      start_op(KV[0], PV[0]);
      start = 1'b1;
      pt = 64'hFFFFFFFFFFFFFFFF;
      key = 64'hFEDCBA9876543210;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (valid === 1'b1) nv++;
      end
      start = 1'b0;
      n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL busy_valid16 got %b want 1", valid); end
      n_cmp++; if (ct !== EV[0]) begin n_fail++; $display("FAIL busy_ct got %h want %h", ct, EV[0]); end
      repeat (20) begin
         @(negedge clk);
         if (valid === 1'b1) nv++;
      end
      n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL busy_nvalid got %0d want 1", nv); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int nv = 0;
      int cyc;
      start_op(KV[2], PV[2]);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ct !== 64'h0) begin n_fail++; $display("FAIL rstmid_ct got %h want %h", ct, 64'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", valid); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (valid === 1'b1) nv++;
      end
      n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_nvalid got %0d want 0", nv); end
      start_op(KV[0], PV[0]);
      wait_valid(cyc);
      n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL rstmid_latency got %0d want 16", cyc); end
      n_cmp++; if (ct !== EV[0]) begin n_fail++; $display("FAIL rstmid_ct2 got %h want %h", ct, EV[0]); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      start_op(KV[1], PV[1]);
      wait_valid(cyc);
      n_cmp++; if (ct !== EV[1]) begin n_fail++; $display("FAIL b2b_ct1 got %h want %h", ct, EV[1]); end
      key = KV[2];
      pt = PV[2];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept17 got %b want 1", busy); end
      wait_valid(cyc);
      n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL b2b_latency got %0d want 16", cyc); end
      n_cmp++; if (ct !== EV[2]) begin n_fail++; $display("FAIL b2b_ct2 got %h want %h", ct, EV[2]); end
   endtask

`ifdef DES_DECRYPT_EN
   task automatic test_decrypt;
      int cyc;
      decrypt = 1'b1;
      start_op(KV[0], EV[0]);
      decrypt = 1'b0;
      wait_valid(cyc);
      n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL dec_latency got %0d want 16", cyc); end
      n_cmp++; if (ct !== PV[0]) begin n_fail++; $display("FAIL dec_ct got %h want %h", ct, PV[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_vectors();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
`ifdef DES_DECRYPT_EN
      test_decrypt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
